// File: rtl/aes_pkg.sv
// Shared types and widths for the SubBytes scheduler: FSM states, grant owner and data widths.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int WORD_W  = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_KEY   = 2'd2
  } state_e;

  typedef enum logic {
    G_ROUND = 1'b0,
    G_KEY   = 1'b1
  } grant_e;

endpackage

// File: rtl/sbox_word.sv
// One 32-bit SubBytes lane: four parallel AES forward S-box lookups, purely combinational.
module sbox_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word_in,
  output logic [WORD_W-1:0] word_out
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign word_out[8*i +: 8] = SBOX[word_in[8*i +: 8]];
  end

endmodule

// File: rtl/subbytes_sched.sv
// Time-shares one 32-bit S-box lane between a 4-cycle round SubBytes and a 1-cycle key SubWord.
module subbytes_sched
  import aes_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STATE_W-1:0] st_in,
  input  logic               st_valid,
  output logic               st_ready,
  output logic [STATE_W-1:0] st_out,
  output logic               st_out_valid,
  input  logic [WORD_W-1:0]  kw_in,
  input  logic               kw_valid,
  output logic               kw_ready,
  output logic [WORD_W-1:0]  kw_out,
  output logic               kw_out_valid,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  state_e             state;
  grant_e             last_grant;
  logic [1:0]         wc;
  logic [STATE_W-1:0] st_cap;
  logic [WORD_W-1:0]  kw_cap;
  logic [WORD_W-1:0]  lane_in;
  logic [WORD_W-1:0]  lane_out;
  logic               idle;
  logic               fair_on;

  assign fair_on   = (FAIR != 0);
  assign idle      = (state == S_IDLE);
  assign busy      = ~idle;
  assign dbg_state = state;

  // A request transfers on a rising edge where valid and ready are both high; ready is only
  // offered in IDLE, and on contention exactly one side sees ready (round-robin or key-first).
  assign st_ready = idle & (~kw_valid | (fair_on & (last_grant == G_KEY)));
  assign kw_ready = idle & (~st_valid | ~fair_on | (last_grant == G_ROUND));

  always_comb begin
    lane_in = kw_cap;
    if (state == S_ROUND) begin
      case (wc)
        2'd0: lane_in = st_cap[127:96];
        2'd1: lane_in = st_cap[95:64];
        2'd2: lane_in = st_cap[63:32];
        2'd3: lane_in = st_cap[31:0];
      endcase
    end
  end

  sbox_word u_lane (
    .word_in  (lane_in),
    .word_out (lane_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      last_grant   <= G_ROUND;
      wc           <= 2'd0;
      st_cap       <= '0;
      kw_cap       <= '0;
      st_out       <= '0;
      kw_out       <= '0;
      st_out_valid <= 1'b0;
      kw_out_valid <= 1'b0;
    end else begin
      st_out_valid <= 1'b0;
      kw_out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (st_valid && st_ready) begin
            st_cap     <= st_in;
            wc         <= 2'd0;
            state      <= S_ROUND;
            last_grant <= G_ROUND;
          end else if (kw_valid && kw_ready) begin
            kw_cap     <= kw_in;
            state      <= S_KEY;
            last_grant <= G_KEY;
          end
        end
        S_ROUND: begin
          // Only the word selected by wc is rewritten; the rest of st_out holds.
          case (wc)
            2'd0: st_out[127:96] <= lane_out;
            2'd1: st_out[95:64]  <= lane_out;
            2'd2: st_out[63:32]  <= lane_out;
            2'd3: st_out[31:0]   <= lane_out;
          endcase
          wc <= wc + 2'd1;
          if (wc == 2'd3) begin
            state        <= S_IDLE;
            st_out_valid <= 1'b1;
          end
        end
        S_KEY: begin
          kw_out       <= lane_out;
          kw_out_valid <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
